mul_share_sched: RTL and testbench
==================================

Name: mul_share_sched

Overview:
- Shares one iterative shift-add multiplier between two requesters, using round-robin arbitration.
- Result is the low WIDTH bits of the product. This is the same modulo-2^WIDTH product our combinational multiplier returns.
- Sits between two client blocks and the shared multiply datapath. It replaces per-client combinational multipliers where area matters more than latency.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in0_valid  in  1  requester 0 has operands.
- in0_ready  out  1  requester 0 operands accepted this cycle.
- in0_a  in  WIDTH  requester 0 multiplicand.
- in0_b  in  WIDTH  requester 0 multiplier.
- in1_valid  in  1  requester 1 has operands.
- in1_ready  out  1  requester 1 operands accepted this cycle.
- in1_a  in  WIDTH  requester 1 multiplicand.
- in1_b  in  WIDTH  requester 1 multiplier.
- res_valid  out  1  one-cycle pulse: result available.
- res_id  out  1  requester the result belongs to.
- res  out  WIDTH  product, low WIDTH bits.
- busy  out  1  high from acceptance until the res_valid cycle, inclusive.

Behaviour:
- Reset (rst=1 at edge), state after reset:
  - state=IDLE; res_valid=0, res=0, res_id=0, busy=0; internal acc, a, b and cnt cleared.
  - rr_last=1, so port 0 has priority first.
  - in0_ready and in1_ready are combinational and 0 while state!=IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Grant selection:
    - only inN_valid -> grant N.
    - both valid -> grant the port != rr_last.
    - none -> stay in IDLE.
  - inN_ready = (state==IDLE) && granted N. It is asserted in the same cycle as valid.
  - Transfer occurs on valid && ready. At that edge: latch a, b and id; acc=0; cnt=WIDTH; rr_last=id; busy=1; go to BUSY.
- BUSY, each cycle:
  - if b[0], acc = acc + a, truncated to WIDTH.
  - a = a << 1 (truncated); b = b >> 1; cnt = cnt - 1.
  - When cnt reaches 0 after the update, go to DONE.
- DONE (exactly one cycle):
  - res_valid=1, res=acc, res_id=latched id, busy=1.
  - Next state is IDLE. No grant is issued in DONE.
- res and res_id hold their value after the pulse until the next DONE. res_valid is 0 outside DONE.
- Latency and throughput:
  - acceptance at edge T -> res_valid high in cycle T+WIDTH+1 (33 for WIDTH=32).
  - maximum one operation per WIDTH+2 cycles.
- Arithmetic and width rules:
  - res = (a*b) mod 2^WIDTH, unsigned.
  - Overflow bits are discarded silently; there is no overflow flag.
- Operand changes on in* while BUSY or DONE are ignored. The latched copies are used.
- Valid held low by a requester after a missed grant is legal; no request is remembered.
- No result backpressure. The consumer must capture res on res_valid.
- Reset mid-operation: the operation is aborted, no res_valid is produced, and rr_last returns to 1.
- Simultaneous rst and valid: rst wins, no ready is taken.

Decomposition:
- Package mul_share_pkg holds:
  - state enum {IDLE, BUSY, DONE}.
  - WIDTH default constant.
  - port id constants PORT0=0, PORT1=1.
- Sub-module mul_iter_dp holds the shift-add datapath: registers a/b/acc/cnt, with inputs load, step and operands, and outputs acc and last.
- The top module keeps the FSM and arbiter.

Test Plan:
- Port 0 only, a=3, b=5 -> in0_ready=1 same cycle; res_valid exactly 33 cycles after acceptance; res=15, res_id=0.
- Port 1 only, a=0xFFFFFFFF, b=0xFFFFFFFF -> res=0x00000001, res_id=1. Also a=0x00010000, b=0x00010000 -> res=0 (truncation).
- Both valid continuously from reset:
  - grants alternate 0,1,0,1, each spaced 34 cycles.
  - port0 7*6 -> 42; port1 9*9 -> 81.
  - ready is never asserted while busy.
- Change in0_a/in0_b every cycle during BUSY after accepting 12*12 -> res=144. No extra ready pulses.
- Assert rst for 1 cycle 10 cycles into an operation:
  - no res_valid follows; all outputs return to reset values.
  - next simultaneous request is granted to port 0.
- Random: 1000 operand pairs on random ports -> every res equals (a*b) mod 2^32 with matching res_id. Per-port results arrive in order.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared definitions for the two-port shared shift-add multiplier.
// Holds the scheduler state encoding, default operand width and port ids.
// Imported by mul_iter_dp and mul_share_sched.
package mul_share_pkg;

  // Default operand/result width of the shared multiplier.
  localparam int WIDTH_DEF = 32;

  // Requester identifiers; also the encoding of res_id and rr_last.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Scheduler states: waiting for a request, iterating, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_iter_dp.sv
// Iterative shift-add multiply datapath: one partial product per step.
// Ports: clk/rst; load latches operands, clears acc, sets cnt=WIDTH;
//        step performs one add/shift; acc is the running product; last flags the final step.
module mul_iter_dp
  import mul_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic             last
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (step) begin
      // Add the shifted multiplicand when the current multiplier bit is set;
      // carries out of the top bit are dropped, giving the modulo product.
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign acc  = acc_q;
  // The step taken while cnt==1 is the final one; cnt hits 0 at that edge.
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one iterative multiplier between two requesters.
// Ports: inN_valid/inN_ready/inN_a/inN_b per requester; res_valid pulse with res/res_id;
//        busy high from acceptance through the result cycle. Result has no backpressure.
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in0_b,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in1_b,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  state_t           state;
  logic             rr_last;
  logic             id_q;
  logic [WIDTH-1:0] res_hold;
  logic             res_id_hold;

  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] dp_acc;
  logic             dp_last;

  // Grant only in IDLE. On contention the port that was not served last wins.
  // rst masks the grant so a request coinciding with reset is not taken.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (in0_valid && in1_valid) begin
        if (rr_last == PORT1) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (in0_valid) begin
        gnt0 = 1'b1;
      end else if (in1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign in0_ready = gnt0;
  assign in1_ready = gnt1;
  assign accept    = gnt0 | gnt1;
  assign sel_a     = gnt1 ? in1_a : in0_a;
  assign sel_b     = gnt1 ? in1_b : in0_b;

  mul_iter_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (state == BUSY),
    .op_a (sel_a),
    .op_b (sel_b),
    .acc  (dp_acc),
    .last (dp_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= PORT1;
      id_q        <= PORT0;
      res_hold    <= '0;
      res_id_hold <= PORT0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q    <= gnt1;
            rr_last <= gnt1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (dp_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Keep the result visible after the pulse; acc is cleared on the next load.
          res_hold    <= dp_acc;
          res_id_hold <= id_q;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res       = res_valid ? dp_acc : res_hold;
  assign res_id    = res_valid ? id_q : res_id_hold;

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // handshake cycle -> result cycle

  logic         clk;
  logic         rst;
  logic         in0_valid, in1_valid;
  logic         in0_ready, in1_ready;
  logic [W-1:0] in0_a, in0_b, in1_a, in1_b;
  logic         res_valid, res_id, busy;
  logic [W-1:0] res;

  mul_share_sched #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_a     (in0_a),
    .in0_b     (in0_b),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_a     (in1_a),
    .in1_b     (in1_b),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res       (res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard (monitor) ----------------
  typedef struct {
    bit           id;
    logic [W-1:0] p;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  bit           m_rr_last = 1'b1;
  int           bstart = 0;
  int           bend = -1;
  logic [W-1:0] hold_res = '0;
  bit           hold_id = 1'b0;

  initial begin : monitor
    bit   idle;
    int   g;
    bit   exp_v;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      // The multiplier is free once the previous result cycle has passed.
      idle = (cyc > bend) && !rst;
      g = -1;
      if (idle) begin
        if (in0_valid && in1_valid) g = m_rr_last ? 0 : 1;
        else if (in0_valid)         g = 0;
        else if (in1_valid)         g = 1;
      end
      chk("in0_ready", W'(in0_ready), W'(g == 0));
      chk("in1_ready", W'(in1_ready), W'(g == 1));
      chk("busy", W'(busy), W'(cyc >= bstart && cyc <= bend));
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("res_valid", W'(res_valid), W'(exp_v));
      if (exp_v) begin
        hold_res = q[0].p;
        hold_id  = q[0].id;
        void'(q.pop_front());
      end
      chk("res", res, hold_res);
      chk("res_id", W'(res_id), W'(hold_id));
      if (rst) begin
        q.delete();
        m_rr_last = 1'b1;
        bstart    = 0;
        bend      = -1;
        hold_res  = '0;
        hold_id   = 1'b0;
      end else if (g >= 0) begin
        e.id  = (g == 1);
        e.p   = (g == 1) ? in1_a * in1_b : in0_a * in0_b;
        e.due = cyc + LAT;
        q.push_back(e);
        m_rr_last = (g == 1);
        bstart    = cyc + 1;
        bend      = cyc + LAT;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit           pend[2];
  logic [W-1:0] pa[2];
  logic [W-1:0] pb[2];
  bit           refill = 1'b0;
  int           n_acc = 0;

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] one;
    one = 1;
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return one << $urandom_range(0, W-1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive();
    in0_valid = pend[0];
    in0_a     = pend[0] ? pa[0] : W'($urandom);
    in0_b     = pend[0] ? pb[0] : W'($urandom);
    in1_valid = pend[1];
    in1_a     = pend[1] ? pa[1] : W'($urandom);
    in1_b     = pend[1] ? pb[1] : W'($urandom);
  endtask

  task automatic step(input bit rand_mode, input bit rst_next);
    bit hs[2];
    @(negedge clk);
    hs[0] = in0_valid && in0_ready;
    hs[1] = in1_valid && in1_ready;
    @(posedge clk);
    #1;
    rst = rst_next;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        pend[p] = 1'b0;
        n_acc++;
      end
      if (rand_mode) begin
        // Requesters may give up after a missed grant, or raise a new request.
        if (pend[p] && $urandom_range(0, 7) == 0) pend[p] = 1'b0;
        else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pa[p]   = rnd_op();
          pb[p]   = rnd_op();
        end
      end
      if (refill && !pend[p]) pend[p] = 1'b1;
    end
    drive();
  endtask

  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[p] = 1'b1;
    pa[p]   = a;
    pb[p]   = b;
  endtask

  initial begin : stim
    int start;
    int guard;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    rst = 1'b1;
    drive();
    repeat (3) step(0, 1);
    step(0, 0);

    // Single-port operations, including wrap-around and truncation.
    set_req(0, 32'd3, 32'd5);
    repeat (40) step(0, 0);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (40) step(0, 0);
    set_req(1, 32'h0001_0000, 32'h0001_0000);
    repeat (40) step(0, 0);

    // Both requesters valid continuously starting out of reset.
    set_req(0, 32'd7, 32'd6);
    set_req(1, 32'd9, 32'd9);
    refill = 1'b1;
    step(0, 1);
    step(0, 0);
    repeat (4 * (W + 2) + 4) step(0, 0);
    refill = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (40) step(0, 0);

    // Operand lines toggle every cycle while the multiplier is busy.
    set_req(0, 32'd12, 32'd12);
    repeat (40) step(0, 0);

    // Reset 10 cycles into an operation, then contend: port 0 must win.
    set_req(1, 32'h0000_1234, 32'h0000_0055);
    repeat (10) step(0, 0);
    step(0, 1);
    step(0, 0);
    set_req(0, rnd_op(), rnd_op());
    set_req(1, rnd_op(), rnd_op());
    repeat (80) step(0, 0);

    // Randomized traffic on both ports.
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 1000 && guard < 60000) begin
      step(1, 0);
      guard++;
    end
    chk("random_budget", W'(guard < 60000), W'(1));

    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (40) step(0, 0);
    chk("drain_empty", W'(q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
